// File: rtl/pe_add_pipe_if.sv
// pe_add_pipe_if
// Handshake and data bundle for the pipelined adder/subtractor.
//   master : producer and consumer side. It drives in_valid, a, b, cin, sub
//            and out_ready, and it observes in_ready, out_valid, sum, cout
//            and ovf.
//   slave  : the adder side, with the opposite directions.
// Ports carried:
//   in_valid / in_ready   input handshake
//   a, b [WIDTH]          operands
//   cin                   carry in
//   sub                   1 = a + ~b + cin, 0 = a + b + cin
//   out_valid / out_ready output handshake
//   sum [WIDTH]           result modulo 2^WIDTH
//   cout                  carry out of the top bit (1 = no borrow when subtracting)
//   ovf                   two's-complement overflow
interface pe_add_pipe_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pe_add_pipe.sv
// pe_add_pipe
// Pipelined carry-lookahead adder/subtractor. The WIDTH-bit operation is
// split into SEG-bit segments, and each of the NSTG = WIDTH/SEG pipeline
// registers is loaded with one more resolved segment.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : pe_add_pipe_if.slave, carrying the valid/ready input and output
//           handshakes, the operands, and sum/cout/ovf
// Latency is NSTG cycles from acceptance to out_valid. Throughput is one
// operation per cycle while the consumer keeps out_ready high.
module pe_add_pipe #(
    parameter int WIDTH = 64,
    parameter int SEG   = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    pe_add_pipe_if.slave bus
);
    localparam int NSTG = WIDTH / SEG;
    localparam int NGRP = SEG / 4;

    logic adv;

    // One segment of lookahead addition. The segment is built from 4-bit
    // groups. Each group carry is formed directly from the segment carry-in
    // as a sum of products of the group generate/propagate terms, so no
    // carry ripples from one group to the next. Result is {carry_out, sum}.
    function automatic logic [SEG:0] cla_seg(
        input logic [SEG-1:0] x,
        input logic [SEG-1:0] y,
        input logic           ci
    );
        logic [SEG-1:0]  g;
        logic [SEG-1:0]  p;
        logic [SEG-1:0]  s;
        logic [NGRP-1:0] gg;
        logic [NGRP-1:0] gp;
        logic [NGRP:0]   gc;
        logic            acc;
        logic            term;
        logic            bc;
        g = x & y;
        p = x ^ y;
        for (int j = 0; j < NGRP; j++) begin
            gg[j] = g[4*j+3]
                  | (p[4*j+3] & g[4*j+2])
                  | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            gp[j] = &p[4*j +: 4];
        end
        for (int j = 0; j <= NGRP; j++) begin
            acc = ci;
            for (int m = 0; m < j; m++) acc = acc & gp[m];
            for (int i = 0; i < j; i++) begin
                term = gg[i];
                for (int m = i + 1; m < j; m++) term = term & gp[m];
                acc = acc | term;
            end
            gc[j] = acc;
        end
        for (int j = 0; j < NGRP; j++) begin
            bc = gc[j];
            for (int i = 0; i < 4; i++) begin
                s[4*j+i] = p[4*j+i] ^ bc;
                bc       = g[4*j+i] | (p[4*j+i] & bc);
            end
        end
        return {gc[NGRP], s};
    endfunction

    // Stage registers are word-rotated. word_reg starts as operand A. Each
    // stage consumes the low SEG bits, and the resolved sum segment is
    // shifted in at the top. After NSTG stages word_reg holds the sum in
    // natural order. The pending B' is shifted down in the same way, so the
    // segment to be resolved next always sits at bits [SEG-1:0].
    // Segment 0 is resolved on the way into the first register. As a result,
    // register NSTG-1 is the output register and the latency is NSTG.
    // Data registers load only behind a valid operation, so bubbles never
    // disturb the held output values.
    genvar gi;
    generate
        for (gi = 0; gi < NSTG; gi++) begin : g_stage
            logic             src_valid;
            logic             src_carry;
            logic [WIDTH-1:0] src_word;
            logic [WIDTH-1:0] src_b;
            logic [WIDTH-1:0] word_next;
            logic [SEG:0]     seg_res;
            logic             valid_reg;
            logic             carry_reg;
            logic [WIDTH-1:0] word_reg;

            if (gi == 0) begin : g_src
                assign src_valid = bus.in_valid && adv;
                assign src_carry = bus.cin;
                assign src_word  = bus.a;
                assign src_b     = bus.b ^ {WIDTH{bus.sub}};
            end else begin : g_src
                assign src_valid = g_stage[gi-1].valid_reg;
                assign src_carry = g_stage[gi-1].carry_reg;
                assign src_word  = g_stage[gi-1].word_reg;
                assign src_b     = g_stage[gi-1].g_bhold.b_reg;
            end

            assign seg_res   = cla_seg(src_word[SEG-1:0], src_b[SEG-1:0], src_carry);
            assign word_next = WIDTH'({seg_res[SEG-1:0], src_word} >> SEG);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg <= 1'b0;
                    carry_reg <= 1'b0;
                    word_reg  <= '0;
                end else if (adv) begin
                    valid_reg <= src_valid;
                    if (src_valid) begin
                        carry_reg <= seg_res[SEG];
                        word_reg  <= word_next;
                    end
                end
            end

            if (gi < NSTG - 1) begin : g_bhold
                logic [WIDTH-1:0] b_reg;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        b_reg <= '0;
                    end else if (adv && src_valid) begin
                        b_reg <= src_b >> SEG;
                    end
                end
            end else begin : g_last
                // The top segment is resolved here. Its operand sign bits
                // sit at bit SEG-1 of the pending words.
                logic ovf_reg;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        ovf_reg <= 1'b0;
                    end else if (adv && src_valid) begin
                        ovf_reg <= (src_word[SEG-1] == src_b[SEG-1])
                                && (seg_res[SEG-1] != src_word[SEG-1]);
                    end
                end
            end
        end
    endgenerate

    assign adv           = !bus.out_valid || bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = g_stage[NSTG-1].valid_reg;
    assign bus.sum       = g_stage[NSTG-1].word_reg;
    assign bus.cout      = g_stage[NSTG-1].carry_reg;
    assign bus.ovf       = g_stage[NSTG-1].g_last.ovf_reg;
endmodule
